// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter presenting the winner as a registered binary index with valid/ready.
// Optional macro RR_ARB_LOCK_EN adds lock_in to hold a grant across consecutive transfers.
module rr_index_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_in,
`ifdef RR_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]   lock_in,
`endif
    output logic                 grant_valid,
    output logic [IDX_WIDTH-1:0] grant_idx,
    input  logic                 grant_ready
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
    logic [IDX_WIDTH-1:0] grant_idx_q, grant_idx_d;
    logic [IDX_WIDTH-1:0] ptr_after_grant;
    logic                 hold_lock;

    // First set request bit at or after start, wrapping modulo NUM_REQ.
    function automatic logic [IDX_WIDTH-1:0] pick_winner(
        input logic [NUM_REQ-1:0]   req,
        input logic [IDX_WIDTH-1:0] start
    );
        logic [IDX_WIDTH-1:0] win;
        logic [NUM_REQ-1:0]   shifted;
        logic                 found;
        int                   cand;
        win   = start;
        found = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = int'(start) + off;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            shifted = req >> cand;
            if (!found && shifted[0]) begin
                win   = IDX_WIDTH'(cand);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    assign ptr_after_grant = (grant_idx_q == IDX_WIDTH'(NUM_REQ - 1)) ? '0
                                                                       : grant_idx_q + 1'b1;

`ifdef RR_ARB_LOCK_EN
    assign hold_lock = lock_in[grant_idx_q] & req_in[grant_idx_q];
`else
    assign hold_lock = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_idx_d = grant_idx_q;
        unique case (state_q)
            IDLE: begin
                if (|req_in) begin
                    state_d     = OFFER;
                    grant_idx_d = pick_winner(req_in, ptr_q);
                end
            end
            OFFER: begin
                // Offer is frozen until the consumer accepts it.
                if (grant_ready) begin
                    if (hold_lock) begin
                        state_d = OFFER;
                    end else begin
                        ptr_d = ptr_after_grant;
                        if (|req_in) begin
                            state_d     = OFFER;
                            grant_idx_d = pick_winner(req_in, ptr_after_grant);
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_idx_q <= grant_idx_d;
        end
    end

    assign grant_valid = (state_q == OFFER);
    assign grant_idx   = grant_idx_q;

endmodule

// File: tb/tb_rr_index_arbiter.sv
// Directed self-checking bench for rr_index_arbiter (NUM_REQ = 4).
module tb_rr_index_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_in;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic       grant_ready;
`ifdef RR_ARB_LOCK_EN
    logic [3:0] lock_in;
`endif

    int checks;
    int errors;

    rr_index_arbiter #(.NUM_REQ(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_in      (req_in),
`ifdef RR_ARB_LOCK_EN
        .lock_in     (lock_in),
`endif
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .grant_ready (grant_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle so outputs can be sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic exp_valid, input logic [1:0] exp_idx);
        checks++;
        if (grant_valid !== exp_valid) begin
            errors++;
            $display("[TB] FAIL %s grant_valid actual=%b expected=%b", name, grant_valid, exp_valid);
        end
        checks++;
        if (exp_valid && grant_idx !== exp_idx) begin
            errors++;
            $display("[TB] FAIL %s grant_idx actual=%0d expected=%0d", name, grant_idx, exp_idx);
        end
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        req_in      = 4'b0000;
        grant_ready = 1'b0;
`ifdef RR_ARB_LOCK_EN
        lock_in     = 4'b0000;
`endif
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        req_in      = 4'b1111;
        grant_ready = 1'b0;
`ifdef RR_ARB_LOCK_EN
        lock_in     = 4'b0000;
`endif
        step();
        step();
        checks++;
        if (grant_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid actual=%b expected=0", grant_valid);
        end
        checks++;
        if (grant_idx !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_idx actual=%0d expected=0", grant_idx);
        end
        rst_n = 1'b1;
        step();
        check_out("reset_first_grant", 1'b1, 2'd0);
    endtask

    task automatic test_rotation();
        logic [1:0] exp_seq [5];
        exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        grant_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_out($sformatf("rotation_%0d", i), 1'b1, exp_seq[i]);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_in      = 4'b0100;
        grant_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_out($sformatf("backpressure_%0d", i), 1'b1, 2'd2);
            if (i == 1) req_in = 4'b0010;
        end
        grant_ready = 1'b1;
        step();
        check_out("backpressure_release", 1'b1, 2'd1);
        req_in = 4'b0000;
        step();
        check_out("backpressure_idle", 1'b0, 2'd1);
    endtask

    task automatic test_skip_wrap();
        do_reset();
        req_in      = 4'b0100;
        grant_ready = 1'b1;
        step();
        check_out("skip_first", 1'b1, 2'd2);
        req_in = 4'b0011;
        step();
        check_out("skip_wrap0", 1'b1, 2'd0);
        step();
        check_out("skip_then1", 1'b1, 2'd1);
        req_in = 4'b0000;
        step();
        check_out("skip_idle", 1'b0, 2'd0);
        checks++;
        if (grant_idx !== 2'd1) begin
            errors++;
            $display("[TB] FAIL idle_hold_idx actual=%0d expected=1", grant_idx);
        end
    endtask

    task automatic test_single_regrant();
        do_reset();
        req_in      = 4'b0001;
        grant_ready = 1'b1;
        step();
        check_out("single_first", 1'b1, 2'd0);
        step();
        check_out("single_regrant", 1'b1, 2'd0);
        req_in = 4'b0011;
        step();
        check_out("regrant_loses_priority", 1'b1, 2'd1);
    endtask

    task automatic test_async_reset();
        do_reset();
        req_in      = 4'b1000;
        grant_ready = 1'b0;
        step();
        check_out("async_pre", 1'b1, 2'd3);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (grant_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_valid actual=%b expected=0", grant_valid);
        end
        checks++;
        if (grant_idx !== 2'd0) begin
            errors++;
            $display("[TB] FAIL async_idx actual=%0d expected=0", grant_idx);
        end
        step();
        req_in = 4'b1111;
        rst_n  = 1'b1;
        step();
        check_out("async_after_release", 1'b1, 2'd0);
    endtask

`ifdef RR_ARB_LOCK_EN
    task automatic test_lock();
        logic [1:0] exp_seq [4];
        exp_seq = '{2'd0, 2'd1, 2'd1, 2'd1};
        do_reset();
        req_in      = 4'b1111;
        lock_in     = 4'b0010;
        grant_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_out($sformatf("lock_%0d", i), 1'b1, exp_seq[i]);
        end
        lock_in = 4'b0000;
        step();
        check_out("lock_release", 1'b1, 2'd2);
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_rotation();
        test_backpressure();
        test_skip_wrap();
        test_single_regrant();
        test_async_reset();
`ifdef RR_ARB_LOCK_EN
        test_lock();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
